// File: rtl/soda_pkg.sv
// Shared definitions for the soda machine datapath slice.
// Holds the value/count widths, default timing parameters and the
// state enums used by the debouncer and the init sequencer.
package soda_pkg;

  localparam int VAL_W = 8;
  localparam int CNT_W = 4;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int INIT_CYCLES_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    HIGH,
    WAIT_LO
  } deb_state_e;

  typedef enum logic {
    INIT,
    READY
  } init_state_e;

endpackage

// File: rtl/soda_datapath_if.sv
// Control/status bus between soda_fsm and soda_datapath.
//   tot_clr, tot_ld, rst_counter, d : commands from the FSM
//   c, tot_lt_s, count, init_done   : status back to the FSM
// master = FSM side, slave = datapath side.
interface soda_datapath_if;
  import soda_pkg::*;

  logic             tot_clr;
  logic             tot_ld;
  logic             rst_counter;
  logic             d;
  logic             c;
  logic             tot_lt_s;
  logic [CNT_W-1:0] count;
  logic             init_done;

  modport master (
    output tot_clr, tot_ld, rst_counter, d,
    input  c, tot_lt_s, count, init_done
  );

  modport slave (
    input  tot_clr, tot_ld, rst_counter, d,
    output c, tot_lt_s, count, init_done
  );

endinterface

// File: rtl/coin_debounce.sv
// Coin sensor conditioning: a 2-flop synchronizer followed by a
// four-state debouncer. Emits a single-cycle pulse on c each time a
// coin is accepted (stable high for DEBOUNCE_CYCLES samples).
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   coin_in : raw, bouncy, asynchronous sensor level
//   c       : one-cycle coin-accepted pulse
module coin_debounce
  import soda_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_in,
  output logic c
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  deb_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;

  // All state registers; reset wipes any partial debounce progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  // Next-state logic. The sample that moves IDLE->WAIT_HI (or HIGH->WAIT_LO)
  // already counts as the first stable sample, so the transition out of the
  // wait state happens on the DEBOUNCE_CYCLES-th consecutive sample.
  always_comb begin
    sync1_d = coin_in;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = DW'(1);
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          c_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = DW'(1);
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q >= LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign c = c_q;

endmodule

// File: rtl/soda_datapath.sv
// Soda machine datapath: coin conditioning, running total with
// saturation, dispense-duration counter, change computation and the
// post-reset init sequencer.
// Ports:
//   clk, rst  : system clock (rising edge), async active-low reset
//   coin_in   : raw coin sensor level
//   coin_val  : value of the coin, captured when the coin is accepted
//   s         : soda price
//   change    : change owed from the last vend
//   fsm       : control/status bus to soda_fsm (slave side)
module soda_datapath
  import soda_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int INIT_CYCLES     = INIT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_in,
  input  logic [VAL_W-1:0] coin_val,
  input  logic [VAL_W-1:0] s,
  output logic [VAL_W-1:0] change,
  soda_datapath_if.slave   fsm
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

  init_state_e      init_q, init_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic [VAL_W-1:0] total_q, total_d;
  logic [VAL_W-1:0] coin_q, coin_d;
  logic [VAL_W-1:0] change_q, change_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             d_q, d_d;
  logic             ready;
  logic             deb_c;
  logic [VAL_W:0]   sum;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .coin_in (coin_in),
    .c       (deb_c)
  );

  // Accepted-coin pulses are masked until initialization completes.
  assign ready         = (init_q == READY);
  assign fsm.init_done = ready;
  assign fsm.c         = deb_c & ready;
  assign fsm.tot_lt_s  = (total_q < s);
  assign fsm.count     = count_q;
  assign change        = change_q;
  assign sum           = {1'b0, total_q} + {1'b0, coin_q};

  // State registers for the sequencer and all datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q     <= INIT;
      init_cnt_q <= '0;
      total_q    <= '0;
      coin_q     <= '0;
      change_q   <= '0;
      count_q    <= '0;
      d_q        <= 1'b0;
    end else begin
      init_q     <= init_d;
      init_cnt_q <= init_cnt_d;
      total_q    <= total_d;
      coin_q     <= coin_d;
      change_q   <= change_d;
      count_q    <= count_d;
      d_q        <= d_d;
    end
  end

  // Init sequencer: count INIT_CYCLES clocks, then stay READY until reset.
  always_comb begin
    init_d     = init_q;
    init_cnt_d = init_cnt_q;
    if (init_q == INIT) begin
      if (init_cnt_q == INIT_LAST) begin
        init_d = READY;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end
  end

  // Datapath update. The coin register captures coin_val at the end of the
  // c cycle, so a tot_ld issued during that same cycle still adds the
  // previously latched coin.
  always_comb begin
    total_d  = total_q;
    count_d  = count_q;
    change_d = change_q;
    d_d      = fsm.d;
    coin_d   = fsm.c ? coin_val : coin_q;
    if (!ready) begin
      total_d  = '0;
      count_d  = '0;
      change_d = '0;
    end else begin
      if (fsm.tot_clr) begin
        total_d = '0;
      end else if (fsm.tot_ld) begin
        total_d = sum[VAL_W] ? {VAL_W{1'b1}} : sum[VAL_W-1:0];
      end

      if (fsm.rst_counter) begin
        count_d = '0;
      end else if (fsm.d && (count_q != {CNT_W{1'b1}})) begin
        count_d = count_q + 1'b1;
      end

      if (fsm.tot_clr) begin
        change_d = '0;
      end else if (fsm.d && !d_q) begin
        change_d = (total_q < s) ? '0 : (total_q - s);
      end
    end
  end

endmodule

// File: tb/tb_soda_datapath.sv
// Self-checking bench for soda_datapath: directed sequences for the
// init, debounce, accumulate, saturation, change and reset scenarios,
// a vector table for the control inputs, and a randomized run compared
// against a behavioural reference model.
module tb_soda_datapath;

  localparam int DEB   = 4;
  localparam int INITC = 8;

  logic       clk;
  logic       rst;
  logic       coin_in;
  logic [7:0] coin_val;
  logic [7:0] s;
  logic [7:0] change;

  int checks;
  int errors;

  soda_datapath_if bus ();

  soda_datapath #(
    .DEBOUNCE_CYCLES(DEB),
    .INIT_CYCLES    (INITC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .coin_in  (coin_in),
    .coin_val (coin_val),
    .s        (s),
    .change   (change),
    .fsm      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: counts clocks since reset, tracks run lengths of the
  // synchronized coin level, and keeps the arithmetic state as integers.
  int m_edges;
  bit m_c;
  int m_total;
  int m_coin;
  int m_count;
  int m_change;
  bit m_dprev;
  bit m_sync1;
  bit m_sync2;
  int m_ones;
  int m_zeros;
  bit m_high;

  typedef struct {
    bit clr;
    bit ld;
    bit rc;
    bit d;
    int s;
    bit exp_lt;
    int exp_count;
    int exp_change;
  } vec_t;

  vec_t vecs[12];

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_edges  = 0;
    m_c      = 0;
    m_total  = 0;
    m_coin   = 0;
    m_count  = 0;
    m_change = 0;
    m_dprev  = 0;
    m_sync1  = 0;
    m_sync2  = 0;
    m_ones   = 0;
    m_zeros  = 0;
    m_high   = 0;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "/c"}, 16'(bus.c), 16'(m_c));
    checkVal({tag, "/tot_lt_s"}, 16'(bus.tot_lt_s), 16'(m_total < int'(s)));
    checkVal({tag, "/count"}, 16'(bus.count), 16'(m_count));
    checkVal({tag, "/init_done"}, 16'(bus.init_done), 16'(m_edges >= INITC));
    checkVal({tag, "/change"}, 16'(change), 16'(m_change));
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge and
  // compare every output against it.
  task automatic applyStimulus(input logic cin, input logic [7:0] cval, input logic [7:0] sv,
                               input logic clr, input logic ld, input logic rc, input logic dd);
    bit rp;
    bit rq;
    bit pulse;
    bit nhigh;
    int nt;
    int ncnt;
    int nch;
    int ncoin;
    int nones;
    int nzeros;
    coin_in         = cin;
    coin_val        = cval;
    s               = sv;
    bus.tot_clr     = clr;
    bus.tot_ld      = ld;
    bus.rst_counter = rc;
    bus.d           = dd;
    rp   = (m_edges >= INITC);
    rq   = (m_edges + 1 >= INITC);
    nt   = m_total;
    ncnt = m_count;
    nch  = m_change;
    if (rp) begin
      if (clr) nt = 0;
      else if (ld) nt = (m_total + m_coin > 255) ? 255 : m_total + m_coin;
      if (rc) ncnt = 0;
      else if (dd) ncnt = (m_count + 1 > 15) ? 15 : m_count + 1;
      if (clr) nch = 0;
      else if (dd && !m_dprev) nch = (m_total >= int'(sv)) ? m_total - int'(sv) : 0;
    end else begin
      nt   = 0;
      ncnt = 0;
      nch  = 0;
    end
    ncoin  = m_c ? int'(cval) : m_coin;
    nones  = m_sync2 ? ((m_ones < 1000) ? m_ones + 1 : m_ones) : 0;
    nzeros = m_sync2 ? 0 : ((m_zeros < 1000) ? m_zeros + 1 : m_zeros);
    nhigh  = m_high;
    pulse  = 0;
    if (!m_high && nones == DEB) begin
      nhigh = 1;
      pulse = 1;
    end else if (m_high && nzeros == DEB) begin
      nhigh = 0;
    end
    @(posedge clk);
    #1;
    m_total  = nt;
    m_count  = ncnt;
    m_change = nch;
    m_coin   = ncoin;
    m_ones   = nones;
    m_zeros  = nzeros;
    m_high   = nhigh;
    m_sync2  = m_sync1;
    m_sync1  = cin;
    m_c      = pulse && rq;
    m_dprev  = dd;
    m_edges  = (m_edges < 1000) ? m_edges + 1 : m_edges;
    checkOutput("step");
  endtask

  task automatic doReset(input string tag);
    rst = 1'b0;
    #1;
    modelReset();
    checkVal({tag, "/rst_c"}, 16'(bus.c), 16'd0);
    checkVal({tag, "/rst_count"}, 16'(bus.count), 16'd0);
    checkVal({tag, "/rst_change"}, 16'(change), 16'd0);
    checkVal({tag, "/rst_init_done"}, 16'(bus.init_done), 16'd0);
    checkVal({tag, "/rst_tot_lt_s"}, 16'(bus.tot_lt_s), 16'(s != 8'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic checkInitSequence(input logic cin);
    for (int i = 1; i <= INITC + 2; i++) begin
      applyStimulus(cin, 8'd25, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);
      checkVal("init_done_seq", 16'(bus.init_done), 16'(i >= INITC));
      checkVal("init_c_quiet", 16'(bus.c), 16'd0);
    end
  endtask

  task automatic insertCoin(input logic [7:0] val, input logic [7:0] sv);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, val, sv, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.c === 1'b1) pulses++;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, val, sv, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.c === 1'b1) pulses++;
    end
    checkVal("coin_pulses", 16'(pulses), 16'd1);
  endtask

  task automatic loadTot(input logic [7:0] sv);
    applyStimulus(1'b0, 8'd0, sv, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Reads the total back through the change path: with price 0 a rising d
  // loads change with the full total.
  task automatic probeTotal(input int exp, input string tag);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal(tag, 16'(change), 16'(exp));
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int pulse_at;
    bit rcin;
    bit rd;
    int run;

    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    coin_in         = 1'b0;
    coin_val        = 8'd0;
    s               = 8'd0;
    bus.tot_clr     = 1'b0;
    bus.tot_ld      = 1'b0;
    bus.rst_counter = 1'b0;
    bus.d           = 1'b0;
    modelReset();
    #2;

    // Power-on reset, coin held high throughout INIT.
    doReset("por");
    checkInitSequence(1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'd25, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bouncy coin followed by a stable high level.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(((i / 2) % 2) == 0, 8'd25, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.c === 1'b1) pulses++;
    end
    checkVal("bounce_no_pulse", 16'(pulses), 16'd0);
    pulse_at = -1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 8'd25, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.c === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
    checkVal("stable_one_pulse", 16'(pulses), 16'd1);
    checkVal("stable_pulse_cycle", 16'(pulse_at), 16'd6);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'd25, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);

    // Accumulate three 25-unit coins against a price of 75.
    applyStimulus(1'b0, 8'd25, 8'd75, 1'b1, 1'b0, 1'b0, 1'b0);
    loadTot(8'd75);
    checkVal("acc1_lt", 16'(bus.tot_lt_s), 16'd1);
    insertCoin(8'd25, 8'd75);
    loadTot(8'd75);
    checkVal("acc2_lt", 16'(bus.tot_lt_s), 16'd1);
    insertCoin(8'd25, 8'd75);
    loadTot(8'd75);
    checkVal("acc3_lt", 16'(bus.tot_lt_s), 16'd0);
    applyStimulus(1'b0, 8'd25, 8'd75, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("clr_prio_lt", 16'(bus.tot_lt_s), 16'd1);
    probeTotal(0, "clr_prio_total");

    // Total saturation and dispense counter saturation.
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b1, 1'b0, 1'b0, 1'b0);
    insertCoin(8'd250, 8'd75);
    loadTot(8'd75);
    probeTotal(250, "total_250");
    insertCoin(8'd25, 8'd75);
    loadTot(8'd75);
    probeTotal(255, "total_sat");
    loadTot(8'd75);
    probeTotal(255, "total_sat_hold");
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 8'd0, 8'd75, 1'b0, 1'b0, 1'b0, 1'b1);
      checkVal("count_ramp", 16'(bus.count), 16'((k > 15) ? 15 : k));
    end
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("count_cleared", 16'(bus.count), 16'd0);

    // Change computation.
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b1, 1'b0, 1'b0, 1'b0);
    insertCoin(8'd100, 8'd75);
    loadTot(8'd75);
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("change_25", 16'(change), 16'd25);
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b1, 1'b0, 1'b0, 1'b0);
    insertCoin(8'd50, 8'd75);
    loadTot(8'd75);
    applyStimulus(1'b0, 8'd0, 8'd20, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("change_30", 16'(change), 16'd30);
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("change_short", 16'(change), 16'd0);
    applyStimulus(1'b0, 8'd0, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);

    // Coin pulse coinciding with tot_ld adds the previously latched coin (50).
    applyStimulus(1'b0, 8'd10, 8'd75, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'd10, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("c_before_add", 16'(bus.c), 16'd1);
    applyStimulus(1'b1, 8'd10, 8'd75, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'd10, 8'd75, 1'b0, 1'b0, 1'b0, 1'b0);
    probeTotal(50, "add_old_coin");
    loadTot(8'd75);
    probeTotal(60, "add_new_coin");

    // Vector table; coin register holds 10 at this point.
    vecs[0]  = '{clr:1, ld:0, rc:1, d:0, s:20, exp_lt:1, exp_count:0, exp_change:0};
    vecs[1]  = '{clr:0, ld:1, rc:0, d:0, s:20, exp_lt:1, exp_count:0, exp_change:0};
    vecs[2]  = '{clr:0, ld:1, rc:0, d:0, s:20, exp_lt:0, exp_count:0, exp_change:0};
    vecs[3]  = '{clr:0, ld:0, rc:0, d:1, s:15, exp_lt:0, exp_count:1, exp_change:5};
    vecs[4]  = '{clr:0, ld:1, rc:0, d:1, s:15, exp_lt:0, exp_count:2, exp_change:5};
    vecs[5]  = '{clr:0, ld:0, rc:0, d:0, s:31, exp_lt:1, exp_count:2, exp_change:5};
    vecs[6]  = '{clr:0, ld:0, rc:0, d:1, s:40, exp_lt:1, exp_count:3, exp_change:0};
    vecs[7]  = '{clr:1, ld:0, rc:0, d:1, s:40, exp_lt:1, exp_count:4, exp_change:0};
    vecs[8]  = '{clr:0, ld:0, rc:1, d:0, s:0,  exp_lt:0, exp_count:0, exp_change:0};
    vecs[9]  = '{clr:0, ld:1, rc:0, d:0, s:0,  exp_lt:0, exp_count:0, exp_change:0};
    vecs[10] = '{clr:0, ld:0, rc:0, d:1, s:3,  exp_lt:0, exp_count:1, exp_change:7};
    vecs[11] = '{clr:0, ld:0, rc:1, d:1, s:3,  exp_lt:0, exp_count:0, exp_change:7};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 8'd0, 8'(vecs[i].s), vecs[i].clr, vecs[i].ld, vecs[i].rc, vecs[i].d);
      checkVal("vec_lt", 16'(bus.tot_lt_s), 16'(vecs[i].exp_lt));
      checkVal("vec_count", 16'(bus.count), 16'(vecs[i].exp_count));
      checkVal("vec_change", 16'(change), 16'(vecs[i].exp_change));
    end

    // Reset in the middle of a held coin and an active dispense.
    applyStimulus(1'b0, 8'd50, 8'd75, 1'b1, 1'b0, 1'b1, 1'b0);
    insertCoin(8'd50, 8'd75);
    loadTot(8'd75);
    applyStimulus(1'b0, 8'd50, 8'd75, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'd50, 8'd75, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("pre_reset_count", 16'(bus.count), 16'd7);
    doReset("mid");
    checkInitSequence(1'b0);

    // Randomized traffic against the model.
    rcin = 0;
    rd   = 0;
    run  = 0;
    for (int i = 0; i < 400; i++) begin
      if (run == 0) begin
        rcin = 1'($urandom_range(0, 1));
        run  = $urandom_range(1, 9);
      end
      run--;
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      applyStimulus(rcin, 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
